// File: rtl/isa_pkg.sv
// isa_pkg: opcode map and select encodings shared by the writeback stage and its decoder
package isa_pkg;
    localparam logic [4:0] OPC_ADDI  = 5'b01000;
    localparam logic [4:0] OPC_SUBI  = 5'b01001;
    localparam logic [4:0] OPC_XORI  = 5'b01010;
    localparam logic [4:0] OPC_ANDNI = 5'b01011;
    localparam logic [4:0] OPC_ROLI  = 5'b10100;
    localparam logic [4:0] OPC_SLLI  = 5'b10101;
    localparam logic [4:0] OPC_RORI  = 5'b10110;
    localparam logic [4:0] OPC_SRLI  = 5'b10111;
    localparam logic [4:0] OPC_ST    = 5'b10000;
    localparam logic [4:0] OPC_LD    = 5'b10001;
    localparam logic [4:0] OPC_SLBI  = 5'b10010;
    localparam logic [4:0] OPC_LBI   = 5'b11000;
    localparam logic [4:0] OPC_BTR   = 5'b11001;
    localparam logic [4:0] OPC_SHF   = 5'b11010;
    localparam logic [4:0] OPC_ARI   = 5'b11011;
    localparam logic [4:0] OPC_SEQ   = 5'b11100;
    localparam logic [4:0] OPC_SLT   = 5'b11101;
    localparam logic [4:0] OPC_SLE   = 5'b11110;
    localparam logic [4:0] OPC_SCO   = 5'b11111;
    localparam logic [4:0] OPC_BEQZ  = 5'b01100;
    localparam logic [4:0] OPC_JAL   = 5'b00110;
    localparam logic [4:0] OPC_JALR  = 5'b00111;

    typedef enum logic [1:0] {DST_RD, DST_RT, DST_RS, DST_LINK} dst_sel_e;
    typedef enum logic [1:0] {SRC_ALU, SRC_MEM, SRC_PC} src_sel_e;
endpackage

// File: rtl/wb_decode.sv
// wb_decode: maps an instruction word to its register write decision, data source and destination
module wb_decode
    import isa_pkg::*;
#(
    parameter int NREG = 8,
    localparam int REG_W = $clog2(NREG)
) (
    input  logic [15:0]      instr,
    output logic             write,
    output src_sel_e         src_sel,
    output logic [REG_W-1:0] dest_reg
);
    logic [6:0] op;
    dst_sel_e dst;
    assign op = {instr[15:11], instr[1:0]};
    always_comb begin
        write = 1'b1;
        src_sel = SRC_ALU;
        dst = DST_RD;
        case (op) inside
            {OPC_ARI, 2'b??}, {OPC_SHF, 2'b??}, {OPC_SEQ, 2'b??}, {OPC_SLT, 2'b??},
            {OPC_SLE, 2'b??}, {OPC_SCO, 2'b??}, {OPC_BTR, 2'b??}: dst = DST_RD;
            {OPC_ADDI, 2'b??}, {OPC_SUBI, 2'b??}, {OPC_XORI, 2'b??}, {OPC_ANDNI, 2'b??},
            {OPC_ROLI, 2'b??}, {OPC_SLLI, 2'b??}, {OPC_RORI, 2'b??}, {OPC_SRLI, 2'b??}: dst = DST_RT;
            {OPC_LBI, 2'b??}, {OPC_SLBI, 2'b??}: dst = DST_RS;
            {OPC_LD, 2'b??}: begin
                dst = DST_RT;
                src_sel = SRC_MEM;
            end
            {OPC_JAL, 2'b??}, {OPC_JALR, 2'b??}: begin
                dst = DST_LINK;
                src_sel = SRC_PC;
            end
            default: write = 1'b0;
        endcase
    end
    // 3-bit fields are sized to REG_W: zero-extended or truncated as needed
    assign dest_reg = dst == DST_RD ? REG_W'(instr[4:2]) :
                      dst == DST_RT ? REG_W'(instr[7:5]) :
                      dst == DST_RS ? REG_W'(instr[10:8]) : REG_W'(NREG - 1);
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage holding one instruction, waiting on load data and pulsing the register-file write
module wb_stage
    import isa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG = 8,
    parameter int CNT_W = 16,
    localparam int REG_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] pc_inc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              mem_done,
    input  logic              mem_err,
    input  logic              flush,
    output logic              wr_en,
    output logic [REG_W-1:0]  wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [1:0] IDLE = 2'd0, WB = 2'd1, WAIT_MEM = 2'd2;
    logic [1:0] state;
    logic [DATA_W-1:0] data_q;
    logic [REG_W-1:0] reg_q;
    logic dec_write, acc;
    src_sel_e dec_src;
    logic [REG_W-1:0] dec_reg;

    wb_decode #(.NREG(NREG)) u_dec (
        .instr(instr),
        .write(dec_write),
        .src_sel(dec_src),
        .dest_reg(dec_reg)
    );

    assign in_ready = !flush && !err && state != WAIT_MEM;
    assign acc = in_valid && in_ready;
    assign busy = state != IDLE;
    // flush kills a write even in the cycle it would have been issued
    assign wr_en = state == WB && !flush;
    assign wr_reg = wr_en ? reg_q : '0;
    assign wr_data = wr_en ? data_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data_q <= '0;
            reg_q <= '0;
            err <= 1'b0;
            retired <= '0;
        end else begin
            if (wr_en && retired != '1) retired <= retired + 1'b1;
            if (flush) state <= IDLE;
            else if (state == WAIT_MEM) begin
                if (mem_err) begin
                    err <= 1'b1;
                    state <= IDLE;
                end else if (mem_done) begin
                    data_q <= mem_out;
                    state <= WB;
                end
            end else if (acc && dec_write) begin
                reg_q <= dec_reg;
                if (dec_src != SRC_MEM) begin
                    data_q <= dec_src == SRC_PC ? pc_inc : alu_out;
                    state <= WB;
                end else if (mem_err) begin
                    err <= 1'b1;
                    state <= IDLE;
                end else if (mem_done) begin
                    data_q <= mem_out;
                    state <= WB;
                end else state <= WAIT_MEM;
            end else state <= IDLE;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of the writeback stage, plus a 4-bit counter instance for saturation
module tb_wb_stage;
    logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, mem_done = 1'b0, mem_err = 1'b0, flush = 1'b0;
    logic [15:0] instr = '0, pc_inc = '0, alu_out = '0, mem_out = '0;
    logic in_ready, wr_en, busy, err;
    logic [2:0] wr_reg;
    logic [15:0] wr_data, retired;
    logic in_ready2, wr_en2, busy2, err2;
    logic [2:0] wr_reg2;
    logic [15:0] wr_data2;
    logic [3:0] retired2;
    int errors = 0, checks = 0;

    localparam logic [15:0] I_ADD  = {5'b11011, 3'd1, 3'd2, 3'd3, 2'b00};
    localparam logic [15:0] I_LD   = {5'b10001, 3'd0, 3'd5, 5'd0};
    localparam logic [15:0] I_JAL  = {5'b00110, 11'd0};
    localparam logic [15:0] I_ADDI = {5'b01000, 3'd1, 3'd2, 5'd3};
    localparam logic [15:0] I_ST   = {5'b10000, 3'd1, 3'd2, 5'd0};
    localparam logic [15:0] I_LBI  = {5'b11000, 3'd4, 8'h12};

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc_inc(pc_inc), .alu_out(alu_out), .mem_out(mem_out), .mem_done(mem_done),
        .mem_err(mem_err), .flush(flush), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .busy(busy), .err(err), .retired(retired)
    );

    wb_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .instr(instr),
        .pc_inc(pc_inc), .alu_out(alu_out), .mem_out(mem_out), .mem_done(mem_done),
        .mem_err(mem_err), .flush(flush), .wr_en(wr_en2), .wr_reg(wr_reg2), .wr_data(wr_data2),
        .busy(busy2), .err(err2), .retired(retired2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_err", err, 0);
        chk("rst_retired", retired, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        in_valid = 1'b1; instr = I_ADD; alu_out = 16'h1234;
        tick();
        in_valid = 1'b0;
        chk("add_wr_en", wr_en, 1);
        chk("add_wr_reg", wr_reg, 3);
        chk("add_wr_data", wr_data, 16'h1234);
        chk("add_busy", busy, 1);
        tick();
        chk("add_wr_en_off", wr_en, 0);
        chk("add_wr_data_off", wr_data, 0);
        chk("add_retired", retired, 1);
        chk("add_idle", busy, 0);

        in_valid = 1'b1; instr = I_LD; mem_out = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        chk("ld_wait_ready1", in_ready, 0);
        chk("ld_wait_busy", busy, 1);
        chk("ld_wait_wr_en", wr_en, 0);
        tick();
        chk("ld_wait_ready2", in_ready, 0);
        tick();
        chk("ld_wait_ready3", in_ready, 0);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("ld_wr_en", wr_en, 1);
        chk("ld_wr_reg", wr_reg, 5);
        chk("ld_wr_data", wr_data, 16'hBEEF);
        tick();
        chk("ld_retired", retired, 2);

        in_valid = 1'b1; instr = I_JAL; pc_inc = 16'h0042;
        tick();
        chk("jal_wr_en", wr_en, 1);
        chk("jal_wr_reg", wr_reg, 7);
        chk("jal_wr_data", wr_data, 16'h0042);
        chk("jal_in_ready", in_ready, 1);
        instr = I_ADDI; alu_out = 16'h5555;
        tick();
        in_valid = 1'b0;
        chk("addi_wr_en", wr_en, 1);
        chk("addi_wr_reg", wr_reg, 2);
        chk("addi_wr_data", wr_data, 16'h5555);
        tick();
        chk("b2b_retired", retired, 4);
        chk("b2b_wr_en_off", wr_en, 0);

        in_valid = 1'b1; instr = I_ST;
        tick();
        in_valid = 1'b0;
        chk("st_wr_en", wr_en, 0);
        chk("st_busy", busy, 0);
        tick();
        chk("st_retired", retired, 4);

        in_valid = 1'b1; instr = I_ADD; alu_out = 16'h0101;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        #1;
        chk("flush_wr_en", wr_en, 0);
        chk("flush_wr_data", wr_data, 0);
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        chk("flush_idle", busy, 0);
        chk("flush_retired", retired, 4);

        in_valid = 1'b1; instr = I_LD;
        tick();
        in_valid = 1'b0; mem_err = 1'b1;
        tick();
        mem_err = 1'b0;
        chk("merr_err", err, 1);
        chk("merr_idle", busy, 0);
        chk("merr_wr_en", wr_en, 0);
        chk("merr_in_ready", in_ready, 0);
        in_valid = 1'b1; instr = I_ADD;
        tick();
        in_valid = 1'b0;
        chk("merr_no_accept", busy, 0);
        chk("merr_err_hold", err, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_err", err, 0);
        chk("rst2_retired", retired, 0);
        in_valid = 1'b1; instr = I_LD;
        tick();
        in_valid = 1'b0;
        chk("rst3_pre_busy", busy, 1);
        rst = 1'b1; mem_done = 1'b1;
        tick();
        rst = 1'b0; mem_done = 1'b0;
        chk("rst3_busy", busy, 0);
        chk("rst3_wr_en", wr_en, 0);
        chk("rst3_wr_data", wr_data, 0);
        chk("rst3_wr_reg", wr_reg, 0);
        chk("rst3_in_ready", in_ready, 1);
        tick();
        chk("rst3_still_idle", wr_en, 0);

        in_valid = 1'b1; instr = I_LD; mem_done = 1'b1; mem_out = 16'h7777;
        tick();
        in_valid = 1'b0; mem_done = 1'b0;
        chk("ldfast_wr_en", wr_en, 1);
        chk("ldfast_wr_data", wr_data, 16'h7777);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; instr = I_LBI; alu_out = 16'h0012;
        tick();
        chk("lbi_wr_reg", wr_reg, 4);
        chk("lbi_wr_data", wr_data, 16'h0012);
        for (int i = 0; i < 16; i++) tick();
        in_valid = 1'b0;
        tick();
        chk("sat_retired", retired2, 15);
        chk("wide_retired", retired, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
